mpif_tx_buffer: RTL and testbench

MPIF_TX_BUFFER -- requirements
Module: mpif_tx_buffer

---
 rtl/mpif_tx_buffer.sv | 182 ++++++++++++++++++
 tb/tb_mpif_tx_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpif_tx_buffer.sv
// mpif_tx_buffer: byte FIFO between the FCS stage and the PHY transmit
// interface. A frame is collected until START_THRESHOLD bytes are held, or
// until its last byte is written, and is then streamed to the PHY in write
// order. Each entry carries a last-of-frame flag next to the data byte.
//
// Optional feature macro: MPIF_TX_UNDERRUN_DET_EN
//   defined   : an empty buffer while streaming, with the PHY ready and no
//               push arriving, pulses txUnderrun_p. The frame is then
//               discarded and the block returns to IDLE.
//   undefined : txUnderrun_p stays 0 and streaming waits for more data.
//
// Ports
//   macCoreClk, macCoreClkHardRst_n : clock, asynchronous active-low reset
//   txFrameStart_p                  : frame start; restarts an active frame
//   txDataIn/txDataInValid          : byte stream from the FCS stage
//   txFrameEnd_p                    : marks this byte, or the next one
//                                     written, as the last of the frame
//   txBufferFlush                   : synchronous abort, highest priority
//   mpIfTxFifoFull                  : back-pressure to the FCS stage
//   phyTxData/phyTxDataValid/
//   phyTxLast/phyTxReady            : head byte handshake to the PHY
//   txBufferEmpty                   : occupancy is zero
//   txUnderrun_p                    : one-cycle underrun pulse
module mpif_tx_buffer #(
  parameter int DEPTH           = 16,
  parameter int START_THRESHOLD = 4
) (
  input  logic       macCoreClk,
  input  logic       macCoreClkHardRst_n,
  input  logic       txFrameStart_p,
  input  logic [7:0] txDataIn,
  input  logic       txDataInValid,
  input  logic       txFrameEnd_p,
  input  logic       txBufferFlush,
  output logic       mpIfTxFifoFull,
  output logic [7:0] phyTxData,
  output logic       phyTxDataValid,
  output logic       phyTxLast,
  input  logic       phyTxReady,
  output logic       txBufferEmpty,
  output logic       txUnderrun_p
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pend_q, pend_d;
  // The frame's last byte is already stored: streaming may end as soon as
  // that byte leaves, and no further data is expected.
  logic            lastSeen_q, lastSeen_d;
  logic            full_q, empty_q;
  logic            unf_q, unf_d;
  logic            push, pop, lastIn, underrun, restart, clr;
  logic [8:0]      head;

  assign head           = mem_q[rdPtr_q];
  assign phyTxData      = head[7:0];
  assign phyTxLast      = head[8];
  assign phyTxDataValid = ((state_q == STREAM) || (state_q == DRAIN)) && !empty_q;
  assign mpIfTxFifoFull = full_q;
  assign txBufferEmpty  = empty_q;
  assign txUnderrun_p   = unf_q;

  assign push    = txDataInValid && !full_q && (state_q != IDLE);
  assign pop     = phyTxDataValid && phyTxReady;
  assign lastIn  = txFrameEnd_p || pend_q;
  assign restart = txFrameStart_p && (state_q != IDLE);

`ifdef MPIF_TX_UNDERRUN_DET_EN
  assign underrun = (state_q == STREAM) && empty_q && phyTxReady && !push;
`else
  assign underrun = 1'b0;
`endif

  // Any of these discards the buffer content on this edge.
  assign clr = txBufferFlush || restart || underrun;

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    pend_d     = pend_q;
    lastSeen_d = lastSeen_q;
    unf_d      = 1'b0;

    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);

    // A frame end without a byte is carried to the next written byte.
    if (push) begin
      pend_d = 1'b0;
      if (lastIn) lastSeen_d = 1'b1;
    end else if (txFrameEnd_p && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (txFrameStart_p) begin
          state_d    = FILL;
          pend_d     = 1'b0;
          lastSeen_d = 1'b0;
        end
      end
      FILL: begin
        if ((count_d >= CW'(START_THRESHOLD)) || (push && lastIn))
          state_d = STREAM;
      end
      STREAM: begin
        // A one-byte tail can leave while still in STREAM.
        if (pop && phyTxLast) begin
          state_d    = IDLE;
          pend_d     = 1'b0;
          lastSeen_d = 1'b0;
        end else if ((push && lastIn) || lastSeen_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && phyTxLast) begin
          state_d    = IDLE;
          pend_d     = 1'b0;
          lastSeen_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      pend_d     = 1'b0;
      lastSeen_d = 1'b0;
      if (txBufferFlush) begin
        state_d = IDLE;
      end else if (restart) begin
        state_d = FILL;
      end else begin
        state_d = IDLE;
        unf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      lastSeen_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      lastSeen_q <= lastSeen_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      unf_q      <= unf_d;
    end
  end

  // Storage is not reset; the head is only looked at while valid.
  always_ff @(posedge macCoreClk) begin
    if (push && !clr) mem_q[wrPtr_q] <= {lastIn, txDataIn};
  end

endmodule

// File: tb/tb_mpif_tx_buffer.sv
module tb_mpif_tx_buffer;
  localparam int DEPTH = 16;
  localparam int THR   = 4;
`ifdef MPIF_TX_UNDERRUN_DET_EN
  localparam bit UDET = 1'b1;
`else
  localparam bit UDET = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       start = 1'b0, vin = 1'b0, fend = 1'b0, flush = 1'b0, rdy = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, pv, plast, empty, unf;
  logic [7:0] pd;

  always #5 clk = ~clk;

  mpif_tx_buffer #(.DEPTH(DEPTH), .START_THRESHOLD(THR)) dut (
    .macCoreClk(clk), .macCoreClkHardRst_n(rst_n),
    .txFrameStart_p(start), .txDataIn(din), .txDataInValid(vin),
    .txFrameEnd_p(fend), .txBufferFlush(flush),
    .mpIfTxFifoFull(full), .phyTxData(pd), .phyTxDataValid(pv),
    .phyTxLast(plast), .phyTxReady(rdy), .txBufferEmpty(empty),
    .txUnderrun_p(unf));

  int n_chk = 0, n_fail = 0;

  // Reference model: mode 0 idle, 1 collecting, 2 sending to the PHY.
  int         m_mode = 0, m_cnt = 0;
  bit         m_pend = 0, m_seen = 0, m_unf = 0;
  logic [8:0] mq[$];   // model buffer content {last, data}
  logic [8:0] sb[$];   // expected PHY output order
  logic [7:0] fr[$];   // bytes of the frame being offered
  int         rmode = 0, fcyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mclr();
    mq.delete(); sb.delete();
    m_cnt = 0; m_pend = 0; m_seen = 0;
  endtask

  function automatic bit next_rdy();
    bit r;
    case (rmode)
      0: r = 1'b1;
      1: r = ($urandom_range(3) != 0);
      2: r = (fcyc >= 24);
      default: r = 1'b0;
    endcase
    fcyc++;
    return r;
  endfunction

  // One clock: drive at negedge, advance the model at the following posedge.
  task automatic step(input bit s, input bit v, input logic [7:0] d, input bit e,
                      input bit f, input bit r, output bit acc);
    bit psh, pp, un, lst;
    int pre;
    logic [8:0] h;
    @(negedge clk);
    start = s; vin = v; din = d; fend = e; flush = f; rdy = r;
    psh = v && (m_cnt != DEPTH) && (m_mode != 0);
    pp  = (m_mode == 2) && (m_cnt > 0) && r;
    un  = UDET && (m_mode == 2) && !m_seen && (m_cnt == 0) && r && !psh;
    lst = e || m_pend;
    pre = m_mode;
    @(posedge clk);
    m_unf = 0; acc = 0;
    if (f) begin
      mclr(); m_mode = 0;
    end else if (s && pre != 0) begin
      mclr(); m_mode = 1;
    end else if (un) begin
      mclr(); m_mode = 0; m_unf = 1;
    end else begin
      if (s) m_mode = 1;
      if (pp) begin
        h = mq.pop_front();
        if (h[8]) begin m_mode = 0; m_seen = 0; m_pend = 0; end
      end
      if (psh) begin
        mq.push_back({lst, d}); sb.push_back({lst, d});
        acc = 1; m_pend = 0;
        if (lst) m_seen = 1;
      end else if (e && pre != 0) begin
        m_pend = 1;
      end
      if (pre == 1 && (mq.size() >= THR || (psh && lst))) m_mode = 2;
    end
    m_cnt = mq.size();
  endtask

  // Offer the bytes in fr as one frame, holding each byte until accepted.
  // abort_kind: 1 flush before byte abort_at, 2 new start before byte abort_at.
  task automatic run_frame(input bit do_start, input int gap_pct, input int rm,
                           input bit pend_end, input int abort_at, input int abort_kind);
    bit acc;
    int tries;
    rmode = rm; fcyc = 0;
    if (do_start) step(1, 0, 8'h00, 0, 0, next_rdy(), acc);
    for (int i = 0; i < fr.size(); i++) begin
      if (abort_kind != 0 && i == abort_at) begin
        if (abort_kind == 1) step(0, 0, 8'h00, 0, 1, next_rdy(), acc);
        else                 step(1, 0, 8'h00, 0, 0, next_rdy(), acc);
        return;
      end
      if (pend_end && i == fr.size() - 1) step(0, 0, 8'h00, 1, 0, next_rdy(), acc);
      else if ($urandom_range(99) < gap_pct) step(0, 0, 8'h00, 0, 0, next_rdy(), acc);
      tries = 0;
      do begin
        step(0, 1, fr[i], (!pend_end && i == fr.size() - 1 && tries == 0), 0, next_rdy(), acc);
        tries++;
      end while (!acc && m_mode != 0 && tries < 200);
    end
    tries = 0;
    while (m_mode != 0 && tries < 400) begin
      step(0, 0, 8'h00, 0, 0, next_rdy(), acc);
      tries++;
    end
  endtask

  // Monitor: checks presented outputs and consumes the scoreboard on pops.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk); #1;
      chk("valid", 32'(pv), 32'((m_mode == 2) && (m_cnt > 0)));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("underrun", 32'(unf), 32'(m_unf));
      if (pv && rdy) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got byte %0h expected no output at %0t", pd, $time);
        end else begin
          e = sb.pop_front();
          chk("data", 32'(pd), 32'(e[7:0]));
          chk("last", 32'(plast), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    bit acc, skip;
    int n, ak;
    #1 rst_n = 1'b0;
    mclr(); m_mode = 0; m_unf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // 10 sequential bytes, end with the last, PHY always ready
    fr.delete(); for (int i = 0; i < 10; i++) fr.push_back(8'(i));
    run_frame(1, 0, 0, 0, 0, 0);

    // 20 bytes against a stalled PHY: fills to DEPTH, then resumes
    fr.delete(); for (int i = 0; i < 20; i++) fr.push_back(8'(8'h40 + i));
    run_frame(1, 0, 2, 0, 0, 0);

    // end pulse in a gap cycle, last byte 0x55 written afterwards
    fr.delete(); fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33); fr.push_back(8'h55);
    run_frame(1, 0, 0, 1, 0, 0);

    // flush with 8 bytes stored
    fr.delete(); for (int i = 0; i < 12; i++) fr.push_back(8'(8'h80 + i));
    run_frame(1, 0, 3, 0, 8, 1);
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, acc);

    // source stops after 4 bytes while the PHY keeps pulling
    step(1, 0, 8'h00, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'hA0 + i), 0, 0, 0, acc);
    repeat (8) step(0, 0, 8'h00, 0, 0, 1, acc);
    step(0, 1, 8'hA4, 0, 0, 1, acc);
    repeat (3) step(0, 0, 8'h00, 0, 0, 1, acc);
    step(0, 0, 8'h00, 0, 1, 0, acc);

    // reset with 5 bytes held while streaming
    step(1, 0, 8'h00, 0, 0, 0, acc);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'hC0 + i), 0, 0, 0, acc);
    step(0, 0, 8'h00, 0, 0, 0, acc);
    #3 rst_n = 1'b0;
    mclr(); m_mode = 0; m_unf = 0;
    #1;
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_valid", 32'(pv), 32'(0));
    chk("rst_underrun", 32'(unf), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (6) step(0, 1, 8'h77, 0, 0, 1, acc);
    step(0, 0, 8'h00, 0, 0, 1, acc);

    // randomized frames
    skip = 0;
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(40, 1);
      fr.delete(); repeat (n) fr.push_back(8'($urandom));
      ak = ($urandom_range(9) == 0) ? 1 : (($urandom_range(9) == 0) ? 2 : 0);
      run_frame(!skip, $urandom_range(40), $urandom_range(1), 1'($urandom_range(1)),
                $urandom_range(n - 1), ak);
      skip = (ak == 2);
      repeat ($urandom_range(3)) step(0, 0, 8'h00, 0, 0, 1, acc);
    end
    step(0, 0, 8'h00, 0, 1, 0, acc);
    repeat (2) step(0, 0, 8'h00, 0, 0, 0, acc);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end
endmodule
